// File: rtl/pulse_train_gen.sv
// pulse_train_gen - multi-channel programmable pulse-train generator.
//
// One shared period counter (cnt, 0..P) drives CHANNELS pulse outputs, each
// with its own phase offset, high width and enable. Runs continuously
// (glb_burst = 0) or for glb_burst periods. Shadow config is copied to the
// active set only at start and at period wraps, so every period is glitch-free.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   cfg_we      per-channel config write strobe
//   cfg_ch      channel index for cfg_we (values >= CHANNELS ignored)
//   cfg_en      channel enable
//   cfg_phase   channel phase offset, cycles
//   cfg_high    channel high width, cycles
//   glb_we      global config write strobe
//   glb_period  period minus one (P)
//   glb_burst   burst length in periods, 0 = continuous
//   start       start request (level, accepted in IDLE only)
//   stop        graceful stop request (level, latched in RUN)
//   pulse       registered pulse outputs
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle pulse on burst/stop completion
module pulse_train_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int BURST_W  = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic                                               cfg_en,
    input  logic [CNT_W-1:0]                                   cfg_phase,
    input  logic [CNT_W-1:0]                                   cfg_high,
    input  logic                                               glb_we,
    input  logic [CNT_W-1:0]                                   glb_period,
    input  logic [BURST_W-1:0]                                 glb_burst,
    input  logic                                               start,
    input  logic                                               stop,
    output logic [CHANNELS-1:0]                                pulse,
    output logic                                               busy,
    output logic                                               done
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] bcnt;
    logic               stop_lat;

    // shadow configuration (written any time)
    logic [CHANNELS-1:0] sh_en;
    logic [CNT_W-1:0]    sh_phase [CHANNELS];
    logic [CNT_W-1:0]    sh_high  [CHANNELS];
    logic [CNT_W-1:0]    sh_period;
    logic [BURST_W-1:0]  sh_burst;

    // active configuration (used by the running period)
    logic [CHANNELS-1:0] act_en;
    logic [CNT_W-1:0]    act_phase [CHANNELS];
    logic [CNT_W-1:0]    act_high  [CHANNELS];
    logic [CNT_W-1:0]    act_period;
    logic [BURST_W-1:0]  act_burst;

    logic                wrap;
    logic                load_active;
    logic                finish;
    logic [CHANNELS-1:0] hit;

    assign wrap        = (state == ST_RUN) && (cnt == act_period);
    assign load_active = ((state == ST_IDLE) && start) || wrap;
    assign finish      = stop_lat || stop ||
                         ((act_burst != '0) && (bcnt == act_burst - BURST_W'(1)));

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Window test in CNT_W+1 bits so phase + high cannot wrap; cnt never
    // exceeds P, which clips any window extending past the period end.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hit[i] = act_en[i] &&
                     ({1'b0, cnt} >= {1'b0, act_phase[i]}) &&
                     ({1'b0, cnt} < ({1'b0, act_phase[i]} + {1'b0, act_high[i]}));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_en     <= '0;
            sh_period <= '0;
            sh_burst  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sh_phase[i] <= '0;
                sh_high[i]  <= '0;
            end
        end else begin
            if (glb_we) begin
                sh_period <= glb_period;
                sh_burst  <= glb_burst;
            end
            if (cfg_we) begin
                // Out-of-range indices match no channel and are dropped.
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (cfg_ch == CH_W'(i)) begin
                        sh_en[i]    <= cfg_en;
                        sh_phase[i] <= cfg_phase;
                        sh_high[i]  <= cfg_high;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_en     <= '0;
            act_period <= '0;
            act_burst  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                act_phase[i] <= '0;
                act_high[i]  <= '0;
            end
        end else if (load_active) begin
            act_en     <= sh_en;
            act_period <= sh_period;
            act_burst  <= sh_burst;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                act_phase[i] <= sh_phase[i];
                act_high[i]  <= sh_high[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bcnt     <= '0;
            stop_lat <= 1'b0;
            pulse    <= '0;
        end else begin
            pulse <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        cnt      <= '0;
                        bcnt     <= '0;
                        stop_lat <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pulse <= hit;
                    if (stop) begin
                        stop_lat <= 1'b1;
                    end
                    if (wrap) begin
                        cnt  <= '0;
                        bcnt <= bcnt + BURST_W'(1);
                        if (finish) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
